// File: rtl/cmd_cfg.sv
// Command processor behind the UART receiver. It decodes setpoint and control commands,
// sequences motor spin-up and calibration, and returns a one-byte response. A watchdog zeroes the setpoints if the link goes quiet.
module cmd_cfg #(
    parameter int FAST_SIM = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        clr_cmd_rdy,
    output logic [7:0]  resp,
    output logic        send_resp,
    input  logic        resp_sent,
    input  logic        cal_done,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic [8:0]  thrst,
    output logic        strt_cal,
    output logic        inertial_cal,
    output logic        motors_off
);

    localparam int TW = (FAST_SIM != 0) ? 9 : 26;
    localparam logic [TW-1:0] T_MAX = '1;
    localparam logic [TW-1:0] T_ONE = TW'(1);

    localparam logic [7:0] CMD_SET_PTCH  = 8'h02;
    localparam logic [7:0] CMD_SET_ROLL  = 8'h03;
    localparam logic [7:0] CMD_SET_YAW   = 8'h04;
    localparam logic [7:0] CMD_SET_THRST = 8'h05;
    localparam logic [7:0] CMD_CALIBRATE = 8'h06;
    localparam logic [7:0] CMD_EMER_LAND = 8'h07;
    localparam logic [7:0] CMD_MTRS_OFF  = 8'h08;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_ERR = 8'hEE;

    // state     | meaning
    // IDLE      | waiting for a command frame
    // SPINUP    | motors enabled, spin-up timer running
    // CAL_WAIT  | calibration started, waiting for cal_done
    // ACK       | single-cycle send_resp pulse
    // WAIT_SENT | waiting for the response byte to leave
    typedef enum logic [2:0] {
        IDLE,
        SPINUP,
        CAL_WAIT,
        ACK,
        WAIT_SENT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] spin_q, spin_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic [15:0]   ptch_q, ptch_d;
    logic [15:0]   roll_q, roll_d;
    logic [15:0]   yaw_q, yaw_d;
    logic [8:0]    thrst_q, thrst_d;
    logic [7:0]    resp_q, resp_d;
    logic          ical_q, ical_d;
    logic          moff_q, moff_d;
    logic          accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            spin_q  <= '0;
            wdog_q  <= '0;
            ptch_q  <= '0;
            roll_q  <= '0;
            yaw_q   <= '0;
            thrst_q <= '0;
            resp_q  <= 8'h00;
            ical_q  <= 1'b0;
            moff_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            spin_q  <= spin_d;
            wdog_q  <= wdog_d;
            ptch_q  <= ptch_d;
            roll_q  <= roll_d;
            yaw_q   <= yaw_d;
            thrst_q <= thrst_d;
            resp_q  <= resp_d;
            ical_q  <= ical_d;
            moff_q  <= moff_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        spin_d      = spin_q;
        ptch_d      = ptch_q;
        roll_d      = roll_q;
        yaw_d       = yaw_q;
        thrst_d     = thrst_q;
        resp_d      = resp_q;
        ical_d      = ical_q;
        moff_d      = moff_q;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        strt_cal    = 1'b0;
        accept      = 1'b0;

        // Watchdog zeroing goes first so an accepted command below overrides it.
        if (wdog_q == T_MAX) begin
            ptch_d  = '0;
            roll_d  = '0;
            yaw_d   = '0;
            thrst_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_rdy && rst_n) begin
                    accept      = 1'b1;
                    clr_cmd_rdy = 1'b1;
                    state_d     = ACK;
                    resp_d      = RESP_ACK;
                    case (cmd)
                        CMD_SET_PTCH:  ptch_d  = data;
                        CMD_SET_ROLL:  roll_d  = data;
                        CMD_SET_YAW:   yaw_d   = data;
                        CMD_SET_THRST: thrst_d = data[8:0];
                        CMD_CALIBRATE: begin
                            moff_d  = 1'b0;
                            ical_d  = 1'b1;
                            spin_d  = '0;
                            resp_d  = resp_q;
                            state_d = SPINUP;
                        end
                        CMD_EMER_LAND: begin
                            ptch_d  = '0;
                            roll_d  = '0;
                            yaw_d   = '0;
                            thrst_d = '0;
                        end
                        CMD_MTRS_OFF:  moff_d  = 1'b1;
                        default:       resp_d  = RESP_ERR;
                    endcase
                end
            end
            SPINUP: begin
                if (spin_q == T_MAX) begin
                    strt_cal = 1'b1;
                    state_d  = CAL_WAIT;
                end else begin
                    spin_d = spin_q + T_ONE;
                end
            end
            CAL_WAIT: begin
                if (cal_done) begin
                    ical_d  = 1'b0;
                    resp_d  = RESP_ACK;
                    state_d = ACK;
                end
            end
            ACK: begin
                send_resp = 1'b1;
                state_d   = WAIT_SENT;
            end
            WAIT_SENT: begin
                if (resp_sent) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Calibration is a deliberate silent period, so the watchdog is held off.
        if (accept || state_q == SPINUP || state_q == CAL_WAIT) begin
            wdog_d = '0;
        end else if (wdog_q != T_MAX) begin
            wdog_d = wdog_q + T_ONE;
        end else begin
            wdog_d = wdog_q;
        end
    end

    assign resp         = resp_q;
    assign d_ptch       = ptch_q;
    assign d_roll       = roll_q;
    assign d_yaw        = yaw_q;
    assign thrst        = thrst_q;
    assign inertial_cal = ical_q;
    assign motors_off   = moff_q;

endmodule

// File: tb/tb_cmd_cfg.sv
// Self-checking bench for cmd_cfg: table of command vectors, a response scoreboard,
// and hand-written sequences for calibration, blocked commands, watchdog and reset.
module tb_cmd_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        cal_done;
    logic [15:0] d_ptch, d_roll, d_yaw;
    logic [8:0]  thrst;
    logic        strt_cal, inertial_cal, motors_off;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb_q[$];
    logic [7:0] exp_r;
    logic [7:0] hold_resp;
    bit         holding = 0;

    cmd_cfg #(.FAST_SIM(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .resp_sent(resp_sent), .cal_done(cal_done), .d_ptch(d_ptch),
        .d_roll(d_roll), .d_yaw(d_yaw), .thrst(thrst), .strt_cal(strt_cal),
        .inertial_cal(inertial_cal), .motors_off(motors_off)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every send_resp pops the response expected when its command was driven.
    always @(negedge clk) begin
        if (!rst_n) begin
            holding = 0;
        end else if (send_resp) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_send_resp: got resp %0h with nothing expected at %0t", resp, $time);
            end else begin
                exp_r = sb_q.pop_front();
                check("resp_value", {24'd0, resp}, {24'd0, exp_r});
            end
            holding   = 1;
            hold_resp = resp;
        end else if (holding && resp_sent) begin
            check("resp_held", {24'd0, resp}, {24'd0, hold_resp});
            holding = 0;
        end
    end

    task automatic issue(input logic [7:0] c, input logic [15:0] d, input bit push, input logic [7:0] er);
        bit got;
        got = 0;
        @(posedge clk); #1;
        cmd = c; data = d; cmd_rdy = 1'b1;
        if (push) sb_q.push_back(er);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (clr_cmd_rdy) got = 1;
        end
        check("accept", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
    endtask

    task automatic finish_resp();
        repeat (3) @(posedge clk);
        #1 resp_sent = 1'b1;
        @(posedge clk); #1 resp_sent = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] c, input logic [15:0] d, input logic [7:0] er);
        issue(c, d, 1, er);
        @(negedge clk);
        check("latency_send_resp", {31'd0, send_resp}, 32'd1);
        check("clr_one_cycle", {31'd0, clr_cmd_rdy}, 32'd0);
        finish_resp();
    endtask

    typedef struct {
        logic [7:0]  c;
        logic [15:0] d;
        logic [7:0]  er;
        logic [15:0] p, r, y;
        logic [8:0]  t;
        logic        mo;
    } vec_t;

    vec_t vt[11];
    int   at;
    int   blocked;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{8'h02, 16'hFF38, 8'hA5, 16'hFF38, 16'h0000, 16'h0000, 9'h000, 1'b1};
        vt[1]  = '{8'h03, 16'h0100, 8'hA5, 16'hFF38, 16'h0100, 16'h0000, 9'h000, 1'b1};
        vt[2]  = '{8'h04, 16'h8000, 8'hA5, 16'hFF38, 16'h0100, 16'h8000, 9'h000, 1'b1};
        vt[3]  = '{8'h05, 16'hFFFF, 8'hA5, 16'hFF38, 16'h0100, 16'h8000, 9'h1FF, 1'b1};
        vt[4]  = '{8'h33, 16'h1234, 8'hEE, 16'hFF38, 16'h0100, 16'h8000, 9'h1FF, 1'b1};
        vt[5]  = '{8'h05, 16'hFE50, 8'hA5, 16'hFF38, 16'h0100, 16'h8000, 9'h050, 1'b1};
        vt[6]  = '{8'h08, 16'h0000, 8'hA5, 16'hFF38, 16'h0100, 16'h8000, 9'h050, 1'b1};
        vt[7]  = '{8'h07, 16'hABCD, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1};
        vt[8]  = '{8'h00, 16'hFFFF, 8'hEE, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1};
        vt[9]  = '{8'h02, 16'h7FFF, 8'hA5, 16'h7FFF, 16'h0000, 16'h0000, 9'h000, 1'b1};
        vt[10] = '{8'h09, 16'h0001, 8'hEE, 16'h7FFF, 16'h0000, 16'h0000, 9'h000, 1'b1};

        rst_n = 1'b0; cmd_rdy = 1'b0; cmd = 8'h00; data = 16'h0000;
        resp_sent = 1'b0; cal_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ptch", {16'd0, d_ptch}, 32'd0);
        check("rst_roll", {16'd0, d_roll}, 32'd0);
        check("rst_yaw", {16'd0, d_yaw}, 32'd0);
        check("rst_thrst", {23'd0, thrst}, 32'd0);
        check("rst_motors_off", {31'd0, motors_off}, 32'd1);
        check("rst_resp", {24'd0, resp}, 32'd0);
        check("rst_send_resp", {31'd0, send_resp}, 32'd0);
        check("rst_ical", {31'd0, inertial_cal}, 32'd0);
        check("rst_strt_cal", {31'd0, strt_cal}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_cmd(vt[i].c, vt[i].d, vt[i].er);
            check("vec_ptch", {16'd0, d_ptch}, {16'd0, vt[i].p});
            check("vec_roll", {16'd0, d_roll}, {16'd0, vt[i].r});
            check("vec_yaw", {16'd0, d_yaw}, {16'd0, vt[i].y});
            check("vec_thrst", {23'd0, thrst}, {23'd0, vt[i].t});
            check("vec_motors_off", {31'd0, motors_off}, {31'd0, vt[i].mo});
        end

        // Calibration: spin-up, single strt_cal, cal_done, then ACK.
        issue(8'h06, 16'h0000, 1, 8'hA5);
        @(negedge clk);
        check("cal_motors_on", {31'd0, motors_off}, 32'd0);
        check("cal_ical_high", {31'd0, inertial_cal}, 32'd1);
        check("cal_no_early_resp", {31'd0, send_resp}, 32'd0);
        at = 0;
        for (int i = 1; i <= 700; i++) begin
            if (i > 1) @(negedge clk);
            if (strt_cal) begin
                at = i;
                break;
            end
        end
        check("strt_cal_window", {31'd0, (at >= 511 && at <= 513)}, 32'd1);
        @(negedge clk);
        check("strt_cal_single", {31'd0, strt_cal}, 32'd0);
        repeat (19) @(negedge clk);
        check("cal_wait_ical", {31'd0, inertial_cal}, 32'd1);
        check("cal_wait_no_resp", {31'd0, send_resp}, 32'd0);
        @(posedge clk); #1 cal_done = 1'b1;
        @(posedge clk); #1 cal_done = 1'b0;
        @(negedge clk);
        check("cal_done_ical_low", {31'd0, inertial_cal}, 32'd0);
        check("cal_send_resp", {31'd0, send_resp}, 32'd1);
        finish_resp();
        check("cal_wdog_held_ptch", {16'd0, d_ptch}, 32'h7FFF);

        run_cmd(8'h03, 16'h0042, 8'hA5);
        check("setpoint_keeps_motors_on", {31'd0, motors_off}, 32'd0);

        // Command pending during WAIT_SENT must wait, then go through on the first IDLE cycle.
        issue(8'h02, 16'h0123, 1, 8'hA5);
        @(negedge clk);
        check("blk_first_latency", {31'd0, send_resp}, 32'd1);
        @(posedge clk); #1;
        cmd = 8'h04; data = 16'h0555; cmd_rdy = 1'b1;
        sb_q.push_back(8'hA5);
        blocked = 0;
        repeat (100) begin
            @(negedge clk);
            if (clr_cmd_rdy) blocked++;
        end
        check("blk_no_clr", blocked, 32'd0);
        check("blk_yaw_untouched", {16'd0, d_yaw}, 32'd0);
        @(posedge clk); #1 resp_sent = 1'b1;
        @(negedge clk);
        check("blk_clr_in_wait_sent", {31'd0, clr_cmd_rdy}, 32'd0);
        @(posedge clk); #1 resp_sent = 1'b0;
        @(negedge clk);
        check("blk_first_idle_accept", {31'd0, clr_cmd_rdy}, 32'd1);
        @(posedge clk); #1 cmd_rdy = 1'b0;
        @(negedge clk);
        check("blk_send_resp", {31'd0, send_resp}, 32'd1);
        finish_resp();
        check("blk_yaw", {16'd0, d_yaw}, 32'h0555);
        check("blk_ptch", {16'd0, d_ptch}, 32'h0123);

        // Reset in the middle of spin-up.
        issue(8'h06, 16'h0000, 0, 8'h00);
        repeat (50) @(negedge clk);
        check("mid_spinup_ical", {31'd0, inertial_cal}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ical", {31'd0, inertial_cal}, 32'd0);
        check("midrst_motors_off", {31'd0, motors_off}, 32'd1);
        check("midrst_ptch", {16'd0, d_ptch}, 32'd0);
        check("midrst_yaw", {16'd0, d_yaw}, 32'd0);
        check("midrst_resp", {24'd0, resp}, 32'd0);
        repeat (600) begin
            @(negedge clk);
            if (strt_cal) check("midrst_no_strt_cal", 32'd1, 32'd0);
        end

        // Watchdog: silence after the last command zeroes the setpoints.
        run_cmd(8'h03, 16'h0100, 8'hA5);
        issue(8'h05, 16'h0080, 1, 8'hA5);
        for (int i = 1; i <= 520; i++) begin
            @(negedge clk);
            if (i == 1) check("wd_latency", {31'd0, send_resp}, 32'd1);
            if (i == 505) begin
                check("wd_roll_before", {16'd0, d_roll}, 32'h0100);
                check("wd_thrst_before", {23'd0, thrst}, 32'h080);
            end
            if (i == 520) begin
                check("wd_roll_zero", {16'd0, d_roll}, 32'd0);
                check("wd_thrst_zero", {23'd0, thrst}, 32'd0);
                check("wd_motors_off_kept", {31'd0, motors_off}, 32'd1);
            end
            if (i == 3) begin
                @(posedge clk); #1 resp_sent = 1'b1;
            end
            if (i == 4) begin
                @(posedge clk); #1 resp_sent = 1'b0;
            end
        end
        run_cmd(8'h05, 16'h0050, 8'hA5);
        check("wd_thrst_restored", {23'd0, thrst}, 32'h050);
        check("wd_roll_still_zero", {16'd0, d_roll}, 32'd0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_cfg.md
Name: cmd_cfg

Overview:
Command processor that sits directly downstream of UART_comm in the Quadcopter. It consumes the cmd_rdy/cmd/data handshake and clears it with clr_cmd_rdy. It updates the flight setpoint registers and sequences motor spin-up plus inertial calibration. It returns a one-byte response through the send_resp/resp_sent interface, and a command watchdog forces an emergency landing if the remote goes silent.

Parameters:
FAST_SIM, 0, 1 shortens both timers to 9 bits for simulation; 0 gives full-length timers.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous active-low
cmd_rdy  in  1  UART_comm has a complete command/data frame
cmd  in  8  command byte, valid while cmd_rdy=1
data  in  16  command data, valid while cmd_rdy=1
clr_cmd_rdy  out  1  one-cycle pulse; consumes the current command
resp  out  8  response byte; held stable from send_resp until resp_sent
send_resp  out  1  one-cycle pulse; starts response transmission
resp_sent  in  1  UART_comm finished sending resp
cal_done  in  1  inertial integrator finished calibrating
d_ptch  out  16  desired pitch (signed)
d_roll  out  16  desired roll (signed)
d_yaw  out  16  desired yaw (signed)
thrst  out  9  desired thrust (unsigned)
strt_cal  out  1  one-cycle pulse that starts calibration
inertial_cal  out  1  high for the whole spin-up and calibration window
motors_off  out  1  forces ESC outputs to zero

Behaviour:
- Reset is synchronous and active-low, sampled on rising clk only; it is honoured mid-operation.
- Reset values: d_ptch, d_roll, d_yaw, thrst = 0; motors_off = 1; resp = 8'h00; clr_cmd_rdy, send_resp, strt_cal, inertial_cal = 0.
- On reset the state returns to IDLE and both timers clear.
- States: IDLE, SPINUP, CAL_WAIT, ACK, WAIT_SENT.
- IDLE with cmd_rdy=1 (Mealy): assert clr_cmd_rdy for that cycle and decode cmd. Registers update at the end of that cycle.
  - 8'h02 SET_PTCH: d_ptch <= data. Next state ACK, resp <= 8'hA5.
  - 8'h03 SET_ROLL: d_roll <= data. Next state ACK, resp <= 8'hA5.
  - 8'h04 SET_YAW: d_yaw <= data. Next state ACK, resp <= 8'hA5.
  - 8'h05 SET_THRST: thrst <= data[8:0]; data[15:9] is ignored. Next state ACK, resp <= 8'hA5.
  - 8'h06 CALIBRATE: motors_off <= 0, inertial_cal <= 1, spin-up timer cleared. Next state SPINUP.
  - 8'h07 EMER_LAND: d_ptch, d_roll, d_yaw, thrst <= 0. Next state ACK, resp <= 8'hA5.
  - 8'h08 MTRS_OFF: motors_off <= 1. Next state ACK, resp <= 8'hA5.
  - Any other cmd: no register change. Next state ACK, resp <= 8'hEE.
- SPINUP: the spin-up timer (26 bits, or 9 bits when FAST_SIM) increments each cycle. When it reaches all-ones: pulse strt_cal for 1 cycle, go to CAL_WAIT.
- CAL_WAIT: hold until cal_done=1, then inertial_cal <= 0, resp <= 8'hA5, go to ACK.
- ACK: send_resp=1 for exactly one cycle, go to WAIT_SENT.
- WAIT_SENT: hold until resp_sent=1, then go to IDLE. resp is unchanged throughout.
- Latency: send_resp asserts exactly 1 cycle after cmd_rdy is accepted in IDLE (non-calibrate commands).
- Commands arriving outside IDLE are not consumed; clr_cmd_rdy stays low. The pending command is accepted on the first IDLE cycle. Frames are never lost and never overwritten.
- Only MTRS_OFF sets motors_off; only CALIBRATE clears it. Setpoint commands do not change motors_off.
- Watchdog: a counter of the same width as the spin-up timer.
  - It clears whenever a command is accepted, and stays held clear in SPINUP and CAL_WAIT.
  - Otherwise it increments, saturating at all-ones.
  - While saturated, d_ptch, d_roll, d_yaw and thrst are forced to 0 every cycle.
  - No response is sent on watchdog expiry, and motors_off is not affected.
- If command acceptance and watchdog saturation happen in the same cycle, the command wins: its register write lands and the counter clears.
- Signed setpoints are stored verbatim, with no clipping or sign handling.

Test Plan:
- Reset, then sample after 1 cycle -> all setpoints 0, motors_off=1, send_resp=0, state IDLE.
- cmd=8'h02, data=16'hFF38 -> clr_cmd_rdy pulses in the accept cycle; d_ptch=16'hFF38; send_resp 1 cycle later with resp=8'hA5; return to IDLE after resp_sent.
- FAST_SIM=1, cmd=8'h06 -> motors_off=0 and inertial_cal=1 next cycle. strt_cal pulses once after 511 cycles. Apply cal_done 20 cycles later -> inertial_cal=0, then resp=8'hA5 is sent.
- cmd=8'h05, data=16'hFFFF -> thrst=9'h1FF. Then cmd=8'h33 -> resp=8'hEE and all registers unchanged.
- Assert cmd_rdy during WAIT_SENT with resp_sent held low for 100 cycles -> no clr_cmd_rdy during that time. The command is accepted on the first IDLE cycle.
- FAST_SIM=1, load d_roll=16'h0100 and thrst=9'h080, then send no commands -> after 511 idle cycles both read 0. The next SET_THRST 9'h050 restores thrst=9'h050.
